dbg_bridge: RTL and testbench
=============================

DBG_BRIDGE -- requirements
Module: dbg_bridge

Interface
REQ-001 Parameter DBGBASE, 16'hFFE0, base address of the 8-register debug window; DBGBASE[3:0] SHALL be zero.
REQ-002 clk  input  1  sole clock; all state changes on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 rx_data  input  8  command/argument byte from host.
REQ-005 rx_valid  input  1  rx_data valid.
REQ-006 rx_ready  output  1  bridge accepts byte; transfer when rx_valid & rx_ready at posedge.
REQ-007 tx_data  output  8  response byte to host.
REQ-008 tx_valid  output  1  tx_data valid.
REQ-009 tx_ready  input  1  host accepts byte; transfer when tx_valid & tx_ready at posedge.
REQ-010 bus_req  output  1  request for ownership of the debug bus.
REQ-011 bus_gnt  input  1  ownership granted.
REQ-012 addr  output  16  debug bus address.
REQ-013 data  output  16  debug bus write data.
REQ-014 din  input  16  debug register read data, combinationally valid while r is high.
REQ-015 r  output  1  debug read strobe.
REQ-016 w  output  2  debug write byte strobes.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 The command byte SHALL decode as follows: 8'b0000_0rrr is read register rrr; 8'b0001_0rrr is write register rrr; every other value is invalid.
REQ-019 The FSM SHALL have the states IDLE, ARG_HI, ARG_LO, REQ, ACC, TX_HI, TX_LO, TX_ERR, plus TX_ACK when enabled (REQ-036).
REQ-020 rx_ready SHALL be high only in IDLE, ARG_HI and ARG_LO.
REQ-021 In IDLE, accepting a read command SHALL go to REQ, a write command to ARG_HI, and an invalid command to TX_ERR.
REQ-022 Accepting a byte in ARG_HI SHALL load data[15:8] and go to ARG_LO; accepting a byte in ARG_LO SHALL load data[7:0] and go to REQ.
REQ-023 In REQ, bus_req SHALL be high; the state SHALL move to ACC on the first posedge with bus_gnt high and hold otherwise, with no timeout.
REQ-024 ACC SHALL last exactly one cycle, with addr = DBGBASE | {rrr,1'b0} and bus_req still high.
REQ-025 For a read in ACC: r=1, w=2'b00, din captured at the closing edge, next state TX_HI.
REQ-026 For a write in ACC: r=0, w=2'b11, data = the assembled word; next state is TX_ACK if enabled, else IDLE.
REQ-027 bus_req SHALL fall in the cycle after ACC. Outside ACC, r=0, w=2'b00 and addr=16'h0000.
REQ-028 TX_HI SHALL present din_captured[15:8]; TX_LO SHALL present din_captured[7:0]; TX_ERR SHALL present 8'hEE. tx_valid SHALL be high in each of these states.
REQ-029 Each TX state SHALL hold tx_data stable until the transfer completes, then advance: TX_HI->TX_LO, TX_LO->IDLE, TX_ERR->IDLE.
REQ-030 Read latency: with bus_gnt tied high, ACC is 2 cycles after the command-accept edge and tx_valid (high byte) is 3 cycles after it.
REQ-031 bus_gnt is ignored outside REQ; its deassertion in ACC does not abort the access.
REQ-032 Back-to-back commands SHALL be supported; the next command is accepted at the earliest in the IDLE cycle after the previous transaction ends.

Reset
REQ-033 While reset is high at posedge: state=IDLE, rx_ready=1 (IDLE), tx_valid=0, bus_req=0, r=0, w=0, addr=0, data=0, captured word=0, busy=0.
REQ-034 Reset mid-operation SHALL discard partial arguments and pending response bytes (tx_valid drops without handshake); no bus strobe SHALL be issued in the reset cycle or the cycle after it.

Configuration
REQ-035 Macro DBG_BRIDGE_ACK_EN SHALL control write acknowledgement.
REQ-036 With DBG_BRIDGE_ACK_EN defined, a write SHALL pass through TX_ACK, which sends 8'hA5 under the REQ-029 rules before IDLE; without it, TX_ACK does not exist and a write produces no response byte.

Structure
REQ-037 Package dbg_bridge_pkg SHALL hold the state encoding, the opcode constants (read 4'h0, write 4'h1), ERR_BYTE 8'hEE and ACK_BYTE 8'hA5.
REQ-038 The design SHALL be a single module with no sub-module.

Verification
REQ-039 The bench SHALL send 8'h05 with bus_gnt=1 and din=16'h1234 -> one r pulse at addr 16'hFFEA, then tx bytes 8'h12, 8'h34, with tx_valid 3 cycles after accept.
REQ-040 The bench SHALL send 8'h14, 8'hBE, 8'hEF -> one w=2'b11 pulse at addr 16'hFFE8 with data 16'hBEEF; 8'hA5 follows only with DBG_BRIDGE_ACK_EN.
REQ-041 The bench SHALL hold bus_gnt=0 for 10 cycles after a read command -> bus_req held high, no r pulse; ACC follows the cycle gnt rises.
REQ-042 The bench SHALL send 8'h28 and 8'h08 -> each returns 8'hEE with no bus activity.
REQ-043 The bench SHALL hold tx_ready=0 for 5 cycles during a read response -> tx_data held at the high byte and rx_ready low throughout.
REQ-044 The bench SHALL assert reset after 8'h13, 8'h55 -> return to IDLE, no w pulse, and a subsequent 8'h01 read completes normally.

Source files
------------

// File: rtl/dbg_bridge_pkg.sv
// Shared types and constants for the byte-serial debug bridge.
// TX_ACK is present only when DBG_BRIDGE_ACK_EN is defined.
package dbg_bridge_pkg;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        ARG_HI = 4'd1,
        ARG_LO = 4'd2,
        REQ    = 4'd3,
        ACC    = 4'd4,
        TX_HI  = 4'd5,
        TX_LO  = 4'd6,
`ifdef DBG_BRIDGE_ACK_EN
        TX_ERR = 4'd7,
        TX_ACK = 4'd8
`else
        TX_ERR = 4'd7
`endif
    } state_t;

    localparam logic [3:0] OP_READ  = 4'h0;
    localparam logic [3:0] OP_WRITE = 4'h1;
    localparam logic [7:0] ERR_BYTE = 8'hEE;
    localparam logic [7:0] ACK_BYTE = 8'hA5;

endpackage

// File: rtl/dbg_bridge.sv
// Host byte stream to debug-register bus bridge: read/write one of 8 registers.
// Define DBG_BRIDGE_ACK_EN to have writes answered with an ACK_BYTE.
module dbg_bridge
    import dbg_bridge_pkg::*;
#(
    parameter logic [15:0] DBGBASE = 16'hFFE0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic [15:0] addr,
    output logic [15:0] data,
    input  logic [15:0] din,
    output logic        r,
    output logic [1:0]  w,
    output logic        busy
);

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic        wr_q, wr_d;
    logic [15:0] data_q, data_d;
    logic [15:0] cap_q, cap_d;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        wr_d     = wr_q;
        data_d   = data_q;
        cap_d    = cap_q;
        rx_ready = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        bus_req  = 1'b0;
        addr     = 16'h0000;
        r        = 1'b0;
        w        = 2'b00;

        case (state_q)
            IDLE: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    idx_d = rx_data[2:0];
                    if (rx_data[7:4] == OP_READ && !rx_data[3]) begin
                        wr_d    = 1'b0;
                        state_d = REQ;
                    end else if (rx_data[7:4] == OP_WRITE && !rx_data[3]) begin
                        wr_d    = 1'b1;
                        state_d = ARG_HI;
                    end else begin
                        state_d = TX_ERR;
                    end
                end
            end
            ARG_HI: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    data_d[15:8] = rx_data;
                    state_d      = ARG_LO;
                end
            end
            ARG_LO: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    data_d[7:0] = rx_data;
                    state_d     = REQ;
                end
            end
            REQ: begin
                bus_req = 1'b1;
                if (bus_gnt) begin
                    state_d = ACC;
                end
            end
            ACC: begin
                // Grant is not re-checked here: once owned, the access always completes.
                bus_req = 1'b1;
                addr    = DBGBASE | {12'h000, idx_q, 1'b0};
                if (wr_q) begin
                    w = 2'b11;
`ifdef DBG_BRIDGE_ACK_EN
                    state_d = TX_ACK;
`else
                    state_d = IDLE;
`endif
                end else begin
                    r       = 1'b1;
                    cap_d   = din;
                    state_d = TX_HI;
                end
            end
            TX_HI: begin
                tx_valid = 1'b1;
                tx_data  = cap_q[15:8];
                if (tx_ready) state_d = TX_LO;
            end
            TX_LO: begin
                tx_valid = 1'b1;
                tx_data  = cap_q[7:0];
                if (tx_ready) state_d = IDLE;
            end
            TX_ERR: begin
                tx_valid = 1'b1;
                tx_data  = ERR_BYTE;
                if (tx_ready) state_d = IDLE;
            end
`ifdef DBG_BRIDGE_ACK_EN
            TX_ACK: begin
                tx_valid = 1'b1;
                tx_data  = ACK_BYTE;
                if (tx_ready) state_d = IDLE;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        // A reset landing on ACC must not let the strobe escape that cycle.
        if (reset) begin
            r = 1'b0;
            w = 2'b00;
        end
    end

    assign data = data_q;
    assign busy = (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            wr_q    <= 1'b0;
            data_q  <= 16'h0000;
            cap_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            data_q  <= data_d;
            cap_q   <= cap_d;
        end
    end

endmodule

// File: tb/tb_dbg_bridge.sv
// Self-checking bench for dbg_bridge: command table plus stall/reset sequences.
// Expected ACK bytes follow DBG_BRIDGE_ACK_EN, matching the design build.
module tb_dbg_bridge;

`ifdef DBG_BRIDGE_ACK_EN
    localparam bit ACK_EN = 1'b1;
`else
    localparam bit ACK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        bus_req;
    logic        bus_gnt;
    logic [15:0] addr;
    logic [15:0] data;
    logic [15:0] din;
    logic        r;
    logic [1:0]  w;
    logic        busy;

    dbg_bridge #(.DBGBASE(16'hFFE0)) dut (
        .clk(clk), .reset(reset),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .bus_req(bus_req), .bus_gnt(bus_gnt),
        .addr(addr), .data(data), .din(din), .r(r), .w(w), .busy(busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int r_cnt = 0;
    int w_cnt = 0;
    logic [15:0] last_addr = 16'h0;
    logic [15:0] last_data = 16'h0;
    logic [7:0]  exp_q[$];
    logic [7:0]  sb_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard and bus monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL tx_unexpected: got %02h expected no byte", tx_data);
            end else begin
                sb_e = exp_q.pop_front();
                check("tx_byte", {24'h0, tx_data}, {24'h0, sb_e});
            end
        end
        if (r) begin
            r_cnt++;
            last_addr = addr;
            check("r_w_exclusive", {30'h0, w}, 32'h0);
        end
        if (w != 2'b00) begin
            w_cnt++;
            last_addr = addr;
            last_data = data;
            check("w_strobe", {30'h0, w}, 32'h3);
        end
        if (!r && w == 2'b00) check("addr_idle_zero", {16'h0, addr}, 32'h0);
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        rx_data  = b;
        rx_valid = 1'b1;
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (rx_ready) break;
        end
        check("rx_accept_timeout", {31'h0, n < 50}, 32'h1);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        for (n = 0; n < 100; n++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) break;
        end
        check("idle_timeout", {31'h0, n < 100}, 32'h1);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        r_cnt = 0;
        w_cnt = 0;
    endtask

    typedef struct {
        logic [7:0]  b0, b1, b2;
        int          nb;
        logic [15:0] din;
        int          exp_r, exp_w;
        logic [15:0] exp_addr, exp_data;
        logic [7:0]  t0, t1;
        int          nt;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'h05, 8'h00, 8'h00, 1, 16'h1234, 1, 0, 16'hFFEA, 16'h0000, 8'h12, 8'h34, 2};
        vecs[1] = '{8'h14, 8'hBE, 8'hEF, 3, 16'h0000, 0, 1, 16'hFFE8, 16'hBEEF, 8'h00, 8'h00, 0};
        vecs[2] = '{8'h28, 8'h00, 8'h00, 1, 16'h0000, 0, 0, 16'h0000, 16'h0000, 8'hEE, 8'h00, 1};
        vecs[3] = '{8'h08, 8'h00, 8'h00, 1, 16'h0000, 0, 0, 16'h0000, 16'h0000, 8'hEE, 8'h00, 1};
        vecs[4] = '{8'h00, 8'h00, 8'h00, 1, 16'hABCD, 1, 0, 16'hFFE0, 16'h0000, 8'hAB, 8'hCD, 2};
        vecs[5] = '{8'h17, 8'h01, 8'h02, 3, 16'h0000, 0, 1, 16'hFFEE, 16'h0102, 8'h00, 8'h00, 0};
        vecs[6] = '{8'h07, 8'h00, 8'h00, 1, 16'hFFFF, 1, 0, 16'hFFEE, 16'h0000, 8'hFF, 8'hFF, 2};
        vecs[7] = '{8'h0F, 8'h00, 8'h00, 1, 16'h0000, 0, 0, 16'h0000, 16'h0000, 8'hEE, 8'h00, 1};

        reset = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b1;
        bus_gnt = 1'b1; din = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rx_ready", {31'h0, rx_ready}, 32'h1);
        check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("rst_bus_req", {31'h0, bus_req}, 32'h0);
        check("rst_r", {31'h0, r}, 32'h0);
        check("rst_w", {30'h0, w}, 32'h0);
        check("rst_data", {16'h0, data}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        clear_counts();

        for (int i = 0; i < 8; i++) begin
            clear_counts();
            din = vecs[i].din;
            if (vecs[i].nt > 0) exp_q.push_back(vecs[i].t0);
            if (vecs[i].nt > 1) exp_q.push_back(vecs[i].t1);
            if (vecs[i].exp_w != 0 && ACK_EN) exp_q.push_back(8'hA5);
            send_byte(vecs[i].b0);
            if (vecs[i].nb > 1) send_byte(vecs[i].b1);
            if (vecs[i].nb > 2) send_byte(vecs[i].b2);
            if (vecs[i].exp_r != 0 || vecs[i].exp_w != 0) begin
                @(negedge clk);
                check("lat_req_bus_req", {31'h0, bus_req}, 32'h1);
                check("lat_req_no_strobe", {30'h0, r, r | w[0]}, 32'h0);
                @(negedge clk);
                check("lat_acc_r", {31'h0, r}, vecs[i].exp_r);
                check("lat_acc_w", {30'h0, w}, (vecs[i].exp_w != 0) ? 32'h3 : 32'h0);
                if (vecs[i].exp_r != 0) begin
                    @(negedge clk);
                    check("lat_tx_valid", {31'h0, tx_valid}, 32'h1);
                    check("lat_bus_req_fall", {31'h0, bus_req}, 32'h0);
                end
            end else begin
                @(negedge clk);
                check("err_tx_valid", {31'h0, tx_valid}, 32'h1);
                check("err_no_bus_req", {31'h0, bus_req}, 32'h0);
            end
            wait_idle();
            $display("[TB] vec %0d cmd %02h: r=%0d w=%0d addr=%04h data=%04h", i, vecs[i].b0,
                     r_cnt, w_cnt, last_addr, last_data);
            check("vec_r_count", r_cnt, vecs[i].exp_r);
            check("vec_w_count", w_cnt, vecs[i].exp_w);
            if (vecs[i].exp_r != 0 || vecs[i].exp_w != 0)
                check("vec_addr", {16'h0, last_addr}, {16'h0, vecs[i].exp_addr});
            if (vecs[i].exp_w != 0)
                check("vec_data", {16'h0, last_data}, {16'h0, vecs[i].exp_data});
        end

        // Grant withheld for 10 cycles after a read command.
        clear_counts();
        bus_gnt = 1'b0;
        din = 16'h5A5A;
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'h5A);
        send_byte(8'h03);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("stall_bus_req", {31'h0, bus_req}, 32'h1);
            check("stall_no_r", {31'h0, r}, 32'h0);
        end
        @(posedge clk); #1;
        bus_gnt = 1'b1;
        @(negedge clk);
        check("gnt_rise_still_req", {31'h0, r}, 32'h0);
        @(negedge clk);
        check("gnt_acc_r", {31'h0, r}, 32'h1);
        check("gnt_acc_addr", {16'h0, addr}, 32'hFFE6);
        wait_idle();
        $display("[TB] gnt stall read: r=%0d", r_cnt);
        check("gnt_r_count", r_cnt, 1);

        // Host back-pressure during a read response.
        clear_counts();
        tx_ready = 1'b0;
        din = 16'h9876;
        exp_q.push_back(8'h98);
        exp_q.push_back(8'h76);
        send_byte(8'h02);
        begin
            int n;
            for (n = 0; n < 20; n++) begin
                @(negedge clk);
                if (tx_valid) break;
            end
            check("txstall_valid_timeout", {31'h0, n < 20}, 32'h1);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("txstall_data", {24'h0, tx_data}, 32'h98);
            check("txstall_valid", {31'h0, tx_valid}, 32'h1);
            check("txstall_rx_ready", {31'h0, rx_ready}, 32'h0);
        end
        @(posedge clk); #1;
        tx_ready = 1'b1;
        wait_idle();
        $display("[TB] tx stall read: r=%0d", r_cnt);

        // Reset with a partial write in flight.
        clear_counts();
        send_byte(8'h13);
        send_byte(8'h55);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_busy", {31'h0, busy}, 32'h0);
        check("midrst_rx_ready", {31'h0, rx_ready}, 32'h1);
        check("midrst_data", {16'h0, data}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        din = 16'h0F0F;
        exp_q.push_back(8'h0F);
        exp_q.push_back(8'h0F);
        send_byte(8'h01);
        wait_idle();
        $display("[TB] post-reset read: r=%0d w=%0d addr=%04h", r_cnt, w_cnt, last_addr);
        check("midrst_w_count", w_cnt, 0);
        check("midrst_r_count", r_cnt, 1);
        check("midrst_addr", {16'h0, last_addr}, 32'hFFE2);

        // Reset drops a pending response without a handshake.
        tx_ready = 1'b0;
        din = 16'h1111;
        send_byte(8'h04);
        repeat (3) @(negedge clk);
        check("pend_tx_valid", {31'h0, tx_valid}, 32'h1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("pend_rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("pend_rst_stays_idle", {31'h0, busy}, 32'h0);
        $display("[TB] pending response discarded by reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
